// File: rtl/layer_pkg.sv
// layer_pkg
// Shared constants for the CNN layer sequencer:
//   LAYER_W        width of a layer code
//   START..FC8     layer codes in network order (START is the idle code)
//   state_t        scheduler FSM state encoding
//   is_last_layer  true for the final layer of the network
package layer_pkg;

  localparam int LAYER_W = 4;

  localparam logic [LAYER_W-1:0] START = LAYER_W'(0);
  localparam logic [LAYER_W-1:0] CONV1 = LAYER_W'(1);
  localparam logic [LAYER_W-1:0] POOL1 = LAYER_W'(2);
  localparam logic [LAYER_W-1:0] CONV2 = LAYER_W'(3);
  localparam logic [LAYER_W-1:0] POOL2 = LAYER_W'(4);
  localparam logic [LAYER_W-1:0] CONV3 = LAYER_W'(5);
  localparam logic [LAYER_W-1:0] CONV4 = LAYER_W'(6);
  localparam logic [LAYER_W-1:0] CONV5 = LAYER_W'(7);
  localparam logic [LAYER_W-1:0] POOL5 = LAYER_W'(8);
  localparam logic [LAYER_W-1:0] FC6   = LAYER_W'(9);
  localparam logic [LAYER_W-1:0] FC7   = LAYER_W'(10);
  localparam logic [LAYER_W-1:0] FC8   = LAYER_W'(11);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic logic is_last_layer(input logic [LAYER_W-1:0] layer);
    return (layer == FC8);
  endfunction

endpackage

// File: rtl/layer_scheduler.sv
// layer_scheduler
// Walks the layer list CONV1..FC8. For each layer it streams the layer's
// weight words from PCIe into the weight RAM, launches the conv/pool engine
// and waits for it to report completion.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, abort        begin a network pass / cancel it
//   pcie_valid/data     incoming weight words; pcie_ready is the accept
//   cfg_layer/cfg_wlen  lookup into the external per-layer weight-count table
//   ld_we/addr/data     weight RAM write port
//   pe_layer/start/done conv/pool engine control
//   busy, finish        pass in progress / pass completed
module layer_scheduler
  import layer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LAYER_W = layer_pkg::LAYER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               pcie_valid,
  input  logic [DATA_W-1:0]  pcie_data,
  output logic               pcie_ready,
  output logic [LAYER_W-1:0] cfg_layer,
  input  logic [ADDR_W-1:0]  cfg_wlen,
  output logic               ld_we,
  output logic [ADDR_W-1:0]  ld_addr,
  output logic [DATA_W-1:0]  ld_data,
  output logic [LAYER_W-1:0] pe_layer,
  output logic               pe_start,
  input  logic               pe_done,
  output logic               busy,
  output logic               finish
);

  state_t             r_state;
  logic [LAYER_W-1:0] r_layer;
  logic [ADDR_W-1:0]  r_count;

  state_t             w_state_nxt;
  logic [LAYER_W-1:0] w_layer_nxt;
  logic [ADDR_W-1:0]  w_count_nxt;

  // State, layer and word-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_layer <= START;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_layer <= w_layer_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state and output decode. The RAM write port is driven straight
  // from the handshake so a word lands in the same cycle it is accepted.
  // Abort is applied last so it overrides every transition and suppresses
  // a write that would otherwise happen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_count_nxt = r_count;
    pcie_ready  = 1'b0;
    ld_we       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    pe_start    = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_layer_nxt = CONV1;
          w_count_nxt = '0;
        end
      end

      S_LOAD: begin
        // A zero weight count (pool layers) skips the transfer entirely.
        if (cfg_wlen == '0) begin
          w_state_nxt = S_LAUNCH;
        end else begin
          pcie_ready = 1'b1;
          if (pcie_valid) begin
            ld_we       = 1'b1;
            ld_addr     = r_count;
            ld_data     = pcie_data;
            w_count_nxt = r_count + ADDR_W'(1);
            if (r_count == cfg_wlen - ADDR_W'(1)) begin
              w_state_nxt = S_LAUNCH;
            end
          end
        end
      end

      S_LAUNCH: begin
        pe_start    = 1'b1;
        w_count_nxt = '0;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (pe_done) begin
          if (is_last_layer(r_layer)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_layer_nxt = r_layer + LAYER_W'(1);
            w_state_nxt = S_LOAD;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_layer_nxt = START;
      w_count_nxt = '0;
      ld_we       = 1'b0;
      ld_addr     = '0;
      ld_data     = '0;
    end
  end

  assign cfg_layer = r_layer;
  assign pe_layer  = r_layer;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign finish    = (r_state == S_DONE);

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler
// Self-checking bench for layer_scheduler: a table of single-cycle vectors
// for handshake/abort/ignored-event corners, full network passes checked
// cycle by cycle against a layer-level model, and a reset-during-WAIT case.
module tb_layer_scheduler;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int LAYER_W = 4;
  localparam int PASS_BUDGET = 5000;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               pcie_valid;
  logic [DATA_W-1:0]  pcie_data;
  logic               pcie_ready;
  logic [LAYER_W-1:0] cfg_layer;
  logic [ADDR_W-1:0]  cfg_wlen;
  logic               ld_we;
  logic [ADDR_W-1:0]  ld_addr;
  logic [DATA_W-1:0]  ld_data;
  logic [LAYER_W-1:0] pe_layer;
  logic               pe_start;
  logic               pe_done;
  logic               busy;
  logic               finish;

  int vectors = 0;
  int miscompares = 0;

  // Weight-count table seen by the scheduler, indexed by layer code.
  logic [ADDR_W-1:0] wlenTab [0:15];

  // Layer-level model state shared between passes.
  logic [3:0] curLayer;
  bit         passActive;
  bit         finished;

  layer_scheduler #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LAYER_W(LAYER_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pcie_valid(pcie_valid),
    .pcie_data (pcie_data),
    .pcie_ready(pcie_ready),
    .cfg_layer (cfg_layer),
    .cfg_wlen  (cfg_wlen),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .pe_layer  (pe_layer),
    .pe_start  (pe_start),
    .pe_done   (pe_done),
    .busy      (busy),
    .finish    (finish)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // External weight-count table lookup.
  always_comb cfg_wlen = wlenTab[cfg_layer];

  typedef struct packed {
    logic        start;
    logic        abort;
    logic        valid;
    logic        done;
    logic [15:0] data;
    logic        eReady;
    logic        eWe;
    logic [15:0] eAddr;
    logic [15:0] eData;
    logic        eBusy;
    logic        eFinish;
    logic        eStart;
    logic [3:0]  eLayer;
  } vec_t;

  vec_t vecs [0:18];

  function automatic vec_t mk(input logic s, input logic a, input logic v, input logic d,
                              input logic [15:0] dat, input logic r, input logic we,
                              input logic [15:0] ad, input logic [15:0] wd, input logic b,
                              input logic f, input logic ps, input logic [3:0] ly);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.done = d; t.data = dat;
    t.eReady = r; t.eWe = we; t.eAddr = ad; t.eData = wd;
    t.eBusy = b; t.eFinish = f; t.eStart = ps; t.eLayer = ly;
    return t;
  endfunction

  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [15:0] dat, input logic d);
    start      = s;
    abort      = a;
    pcie_valid = v;
    pcie_data  = dat;
    pe_done    = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string ctx, input logic r, input logic we, input logic [15:0] ad,
                          input logic [15:0] wd, input logic b, input logic f, input logic ps,
                          input logic [3:0] ly);
    checkOutput({ctx, " pcie_ready"}, 32'(pcie_ready), 32'(r));
    checkOutput({ctx, " ld_we"},      32'(ld_we),      32'(we));
    checkOutput({ctx, " ld_addr"},    32'(ld_addr),    32'(ad));
    checkOutput({ctx, " ld_data"},    32'(ld_data),    32'(wd));
    checkOutput({ctx, " busy"},       32'(busy),       32'(b));
    checkOutput({ctx, " finish"},     32'(finish),     32'(f));
    checkOutput({ctx, " pe_start"},   32'(pe_start),   32'(ps));
    checkOutput({ctx, " pe_layer"},   32'(pe_layer),   32'(ly));
    checkOutput({ctx, " cfg_layer"},  32'(cfg_layer),  32'(ly));
  endtask

  task automatic resetDut();
    @(negedge clk);
    applyStimulus(0, 0, 0, 16'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll("reset", 0, 0, 16'h0, 16'h0, 0, 0, 0, 4'd0);
    curLayer   = 4'd0;
    passActive = 0;
    finished   = 0;
  endtask

  // One full network pass. The model tracks the current layer, how many of
  // its words are still owed, whether the engine is working, and whether a
  // launch is due this cycle; expectations come from those, cycle by cycle.
  task automatic runPass(input string ctx, input int validPct, input int minD, input int maxD,
                         input bit spur, output int nStarts, output int nWrites);
    bit armed, newArmed, loadEntry, pending, engDone, doneCheck;
    int writesLeft, nextAddr, engCnt, cyc;
    logic s, v, d, eReady, eWe;
    logic [15:0] dat, eAddr, eData;
    nStarts = 0; nWrites = 0;
    armed = 0; loadEntry = 0; pending = 0; doneCheck = 0;
    writesLeft = 0; nextAddr = 0; engCnt = 0; cyc = 0;
    passActive = 0;
    while (1) begin
      @(negedge clk);
      s   = (cyc == 0) || (spur && passActive && $urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 99) < validPct);
      dat = 16'($urandom);
      d   = 0;
      engDone = 0;
      if (pending) begin
        if (engCnt == 0) begin
          d = 1;
          engDone = 1;
        end else begin
          engCnt--;
        end
      end else if (spur && $urandom_range(0, 7) == 0) begin
        d = 1;
      end
      applyStimulus(s, 0, v, dat, d);
      #1;
      eReady = passActive && !pending && (writesLeft > 0);
      eWe    = eReady && v;
      eAddr  = eWe ? 16'(nextAddr) : 16'h0;
      eData  = eWe ? dat : 16'h0;
      checkAll(ctx, eReady, eWe, eAddr, eData, passActive, finished, armed, curLayer);
      if (ld_we) nWrites++;
      if (pe_start) nStarts++;
      if (doneCheck) break;

      if (cyc == 0) begin
        passActive = 1;
        finished   = 0;
        curLayer   = 4'd1;
        writesLeft = int'(wlenTab[1]);
        nextAddr   = 0;
        loadEntry  = 1;
        armed      = 0;
      end else begin
        newArmed = 0;
        if (armed) begin
          pending = 1;
          engCnt  = $urandom_range(minD, maxD) - 1;
        end
        if (eWe) begin
          nextAddr++;
          writesLeft--;
          if (writesLeft == 0) newArmed = 1;
        end
        if (loadEntry && wlenTab[curLayer] == 0) newArmed = 1;
        loadEntry = 0;
        if (engDone) begin
          pending = 0;
          if (curLayer == 4'd11) begin
            passActive = 0;
            finished   = 1;
            doneCheck  = 1;
          end else begin
            curLayer   = curLayer + 4'd1;
            writesLeft = int'(wlenTab[curLayer]);
            nextAddr   = 0;
            loadEntry  = 1;
          end
        end
        armed = newArmed;
      end
      cyc++;
      if (cyc > PASS_BUDGET) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s timeout: pass not finished after %0d cycles, expected finish", ctx, cyc);
        break;
      end
    end
  endtask

  initial begin
    int nS, nW, k;
    logic sawStart;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 16; i++) wlenTab[i] = 16'd3;

    resetDut();

    // Table: CONV1 has 4 words with valid toggling, POOL1 skips, CONV2 is
    // aborted on its second handshake, then a fresh start.
    wlenTab[1] = 16'd4; wlenTab[2] = 16'd0; wlenTab[3] = 16'd2;
    wlenTab[4] = 16'd0; wlenTab[8] = 16'd0;
    vecs[0]  = mk(1,0,0,0,16'h0000, 0,0,16'd0,16'h0000, 0,0,0,4'd0);
    vecs[1]  = mk(0,0,1,0,16'hA101, 1,1,16'd0,16'hA101, 1,0,0,4'd1);
    vecs[2]  = mk(0,0,0,0,16'hBEEF, 1,0,16'd0,16'h0000, 1,0,0,4'd1);
    vecs[3]  = mk(0,0,1,0,16'hA102, 1,1,16'd1,16'hA102, 1,0,0,4'd1);
    vecs[4]  = mk(0,0,0,1,16'hBEEF, 1,0,16'd0,16'h0000, 1,0,0,4'd1);
    vecs[5]  = mk(0,0,1,0,16'hA103, 1,1,16'd2,16'hA103, 1,0,0,4'd1);
    vecs[6]  = mk(0,0,0,0,16'hBEEF, 1,0,16'd0,16'h0000, 1,0,0,4'd1);
    vecs[7]  = mk(0,0,1,0,16'hA104, 1,1,16'd3,16'hA104, 1,0,0,4'd1);
    vecs[8]  = mk(0,0,1,0,16'hA105, 0,0,16'd0,16'h0000, 1,0,1,4'd1);
    vecs[9]  = mk(1,0,1,0,16'hA105, 0,0,16'd0,16'h0000, 1,0,0,4'd1);
    vecs[10] = mk(0,0,0,1,16'h0000, 0,0,16'd0,16'h0000, 1,0,0,4'd1);
    vecs[11] = mk(0,0,1,1,16'hC001, 0,0,16'd0,16'h0000, 1,0,0,4'd2);
    vecs[12] = mk(0,0,1,0,16'hC002, 0,0,16'd0,16'h0000, 1,0,1,4'd2);
    vecs[13] = mk(0,0,0,1,16'h0000, 0,0,16'd0,16'h0000, 1,0,0,4'd2);
    vecs[14] = mk(0,0,1,0,16'hA301, 1,1,16'd0,16'hA301, 1,0,0,4'd3);
    vecs[15] = mk(0,1,1,0,16'hA302, 1,0,16'd0,16'h0000, 1,0,0,4'd3);
    vecs[16] = mk(0,0,0,0,16'h0000, 0,0,16'd0,16'h0000, 0,0,0,4'd0);
    vecs[17] = mk(1,0,0,0,16'h0000, 0,0,16'd0,16'h0000, 0,0,0,4'd0);
    vecs[18] = mk(0,0,1,0,16'hA111, 1,1,16'd0,16'hA111, 1,0,0,4'd1);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].valid, vecs[i].data, vecs[i].done);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].eWe, vecs[i].eAddr,
               vecs[i].eData, vecs[i].eBusy, vecs[i].eFinish, vecs[i].eStart, vecs[i].eLayer);
    end

    resetDut();

    // Basic pass: 3 words per conv/fc layer, pools empty, engine takes 5 cycles.
    for (int i = 0; i < 16; i++) wlenTab[i] = 16'd3;
    wlenTab[2] = 16'd0; wlenTab[4] = 16'd0; wlenTab[8] = 16'd0;
    runPass("basic", 100, 5, 5, 0, nS, nW);
    checkOutput("basic pe_start count", 32'(nS), 32'd11);
    checkOutput("basic ld_we count", 32'(nW), 32'd24);

    // Restart from DONE plus randomised passes with spurious start/pe_done.
    for (int p = 0; p < 6; p++) begin
      for (int i = 1; i < 12; i++) wlenTab[i] = 16'($urandom_range(0, 5));
      if (p == 3) resetDut();
      k = 0;
      for (int i = 1; i < 12; i++) k += int'(wlenTab[i]);
      runPass($sformatf("rand%0d", p), $urandom_range(30, 100), 1, 6, 1, nS, nW);
      checkOutput($sformatf("rand%0d pe_start count", p), 32'(nS), 32'd11);
      checkOutput($sformatf("rand%0d ld_we count", p), 32'(nW), 32'(k));
    end

    // Reset while the engine is running (WAIT) must clear everything.
    resetDut();
    for (int i = 1; i < 12; i++) wlenTab[i] = 16'd2;
    @(negedge clk);
    applyStimulus(1, 0, 1, 16'h1234, 0);
    sawStart = 0;
    for (int c = 0; c < 50 && !sawStart; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 1, 16'h1234, 0);
      #1;
      sawStart = pe_start;
    end
    if (!sawStart) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL rstwait timeout: pe_start got 0, expected 1 within 50 cycles");
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 16'h0, 0);
    #1;
    checkOutput("rstwait busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll("rstwait", 0, 0, 16'h0, 16'h0, 0, 0, 0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
Top-level layer sequencer for the CNN accelerator. It walks the fixed layer list CONV1..FC8 in order. For each layer it streams that layer's weight words from the PCIe input into the weight RAM write port, then launches the conv/pool engine for the layer and waits for it to finish. It owns the PCIe ready handshake, the RAM write strobes, the engine's layer select, and the global finish flag.

Parameters:
DATA_W, 16, PCIe/weight word width (matches PCIE_DATA_WIDTH)
ADDR_W, 16, weight RAM address width; also the width of the per-layer weight-count
LAYER_W, 4, width of the layer code

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a full network pass; sampled only in IDLE or DONE
abort  in  1  cancel the pass; return to IDLE
pcie_valid  in  1  pcie_data holds a valid weight word
pcie_data  in  DATA_W  weight word
pcie_ready  out  1  scheduler accepts a word this cycle
cfg_layer  out  LAYER_W  layer code driven to the external weight-count table
cfg_wlen  in  ADDR_W  weight-word count for cfg_layer; combinational, 0 = no weights
ld_we  out  1  weight RAM write enable
ld_addr  out  ADDR_W  weight RAM write address
ld_data  out  DATA_W  weight RAM write data
pe_layer  out  LAYER_W  layer code presented to the conv/pool engine
pe_start  out  1  one-cycle launch pulse to the engine
pe_done  in  1  engine finished the current layer (single-cycle pulse)
busy  out  1  high in every state except IDLE and DONE
finish  out  1  full pass completed

Behaviour:
- Layer codes (shared constants): START=0, CONV1=1, POOL1=2, CONV2=3, POOL2=4, CONV3=5, CONV4=6, CONV5=7, POOL5=8, FC6=9, FC7=10, FC8=11.
- Reset values: layer register = 0, word count = 0, state = IDLE. All outputs are 0: pcie_ready, ld_we, ld_addr, ld_data, pe_layer, pe_start, busy, finish.
- Output mapping: cfg_layer = pe_layer = layer register.
- Five-state FSM: IDLE, LOAD, LAUNCH, WAIT, DONE.
- IDLE -> LOAD on start: layer <= CONV1, count <= 0. So pcie_ready can first go high 1 cycle after start.
- LOAD:
  - If cfg_wlen == 0 on entry (pool layers): go directly to LAUNCH; pcie_ready is never asserted for that layer.
  - Otherwise pcie_ready = 1.
  - Each handshake cycle (pcie_valid & pcie_ready): ld_we = 1, ld_addr = count, ld_data = pcie_data, all combinational in the same cycle; count++.
  - On the handshake where count == cfg_wlen-1: go to LAUNCH; pcie_ready drops the next cycle. Words beyond cfg_wlen are never accepted.
  - pcie_valid low: stall with no write and count held.
- LAUNCH: pe_start = 1 for exactly this one cycle, then go to WAIT. count resets to 0.
- WAIT:
  - On pe_done: if layer == FC8, go to DONE; otherwise layer++ and go to LOAD.
  - The engine may assert pe_done in the cycle right after pe_start; this must be accepted.
- DONE: finish = 1, held until start or abort/rst. start in DONE behaves as in IDLE: finish drops the next cycle and a new pass begins at CONV1.
- Ignored events:
  - pe_done outside WAIT.
  - start in LOAD, LAUNCH or WAIT.
  - pcie_valid outside LOAD.
- Abort: in any state, the next state is IDLE, layer = 0, count = 0, and finish is not set. A word handshaked in the same cycle as abort is not written: abort overrides ld_we.
- Priority: rst > abort > start/FSM transitions.
- Counter: the count register is ADDR_W bits. cfg_wlen = 2^ADDR_W-1 is the maximum; no wrap is permitted.
- Per-pass latency: sum(cfg_wlen) handshake cycles + 2 cycles per layer (LAUNCH plus the WAIT entry) + engine time + 1 cycle into DONE.

Decomposition:
- Package layer_pkg: LAYER_W, the layer-code localparams START..FC8, the state encoding, and a function is_last_layer().
- No sub-module is needed.
- The weight-count table stays external behind the cfg_layer/cfg_wlen interface, so the network shape can change without editing the scheduler.

Test Plan:
- Basic pass: cfg_wlen = 3 for conv/fc layers, 0 for pools; pcie_valid held high; pe_done 5 cycles after each pe_start -> exactly 11 pe_start pulses with pe_layer = 1..11 in order; 24 ld_we beats, ld_addr 0,1,2 per weighted layer; finish=1 after the FC8 pe_done; busy=0.
- Backpressure: CONV1 cfg_wlen = 4 with pcie_valid toggling 1,0,1,0,... -> writes only on valid cycles at addr 0..3; pcie_ready drops after the 4th beat; the 5th word is not accepted.
- Pool skip: layer POOL1 with cfg_wlen = 0 -> pcie_ready stays 0; pe_start asserts 1 cycle after entering LOAD.
- Abort mid-LOAD: abort on a handshake cycle at CONV2 addr 1 -> ld_we=0 that cycle; next cycle state IDLE, pe_layer=0, finish=0; a following start restarts at CONV1, addr 0.
- Spurious/early events: pe_done during LOAD and start during WAIT -> no state change. pe_done in the cycle right after pe_start -> layer advances.
- Reset and restart: rst during WAIT -> all outputs 0 next cycle. start asserted while in DONE -> finish=0 next cycle and a new pass begins at CONV1.
